decode_issue_stage: RTL
=======================

# decode_issue_stage

Registered, parametrised decode-and-issue stage for the RV32I core, between Fetch/MEM instruction delivery and the ALU/LSU. It decodes the RV32I integer ALU, LUI, load and store subsets, reads operands from an internal register file, and tracks in-flight destination registers in a busy-bit scoreboard. Instructions stall on RAW/WAW hazards, and results return on separate ALU and memory write-back ports. Issue uses a valid/ready handshake so downstream units can back-pressure decode.

## Interface
- XLEN, 32, data width of registers, operands and write-back data.
- NUM_REGS, 32, architectural register count: 32 for RV32I, 16 for RV32E. Any rs1/rs2/rd index ≥ NUM_REGS is illegal.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- instr_valid_ip  in  1  instruction offered.
- instr_data_ip  in  32  instruction word.
- instr_ready_op  out  1  stage accepts this cycle (combinational).
- issue_valid_op  out  1  issue bundle valid.
- issue_ready_ip  in  1  ALU/LSU consume bundle.
- alu_operator_op  out  alu_opcode_e  ALU operation (CORE_PKG; AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU codes added to the package).
- alu_operand_a_ex_op, alu_operand_b_ex_op  out  XLEN  ALU operands.
- en_lsu_op  out  1  bundle is a load/store.
- lsu_operator_op  out  load_store_func_code  LB/LH/LW/LBU/LHU/SB/SH/SW.
- mem_wdata_op  out  XLEN  store data (rs2 value).
- rd_op  out  5  destination tag for write-back; 0 when no write-back.
- illegal_instr_op  out  1  one-cycle pulse, an illegal instruction was dropped.
- wb_alu_valid_ip / wb_alu_addr_ip (5) / wb_alu_data_ip (XLEN)  in  ALU write-back port.
- wb_mem_valid_ip / wb_mem_addr_ip (5) / wb_mem_data_ip (XLEN)  in  load write-back port.

## Operation
- Decode:
  - OPCODE_OP: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - OPCODE_OPIMM: ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI. Shift-immediates with bad funct7 are illegal.
  - LUI: operand a = 0, b = U-imm, ALU_ADD.
  - LOAD: ALU_ADD of rs1 + I-imm, en_lsu_op = 1, rd = rd.
  - STORE: ALU_ADD of rs1 + S-imm, mem_wdata_op = rs2, rd_op = 0.
  - Immediates are sign-extended to XLEN.
  - Any other opcode/funct combination is illegal.
- Register file: NUM_REGS×XLEN. x0 reads 0, and writes to x0 are ignored. Reads are combinational. Writes from both ports occur on the same edge. If both ports target the same address, the memory port wins; the scoreboard makes this unreachable in legal use.
- Scoreboard: one busy bit per register.
  - Set on accept of an instruction with rd ≠ 0.
  - Cleared by a write-back valid on either port for that address.
  - A write-back to a non-busy register is still written, and busy stays 0.
- Hazard: asserted if rs1 is busy (all formats except LUI), rs2 is busy (OP and STORE only), or rd ≠ 0 is busy. Hazard checks use the registered busy bits; there is no bypass.
- instr_ready_op = !reset && (!issue_valid_op || issue_ready_ip) && !hazard.
  - Illegal instructions ignore hazard and output fullness: they are always accepted.
  - They are dropped, are not issued, and set no busy bit.
- Issue register: on a legal accept, the bundle loads and issue_valid_op = 1. It clears when consumed with no new accept. While issue_valid_op && !issue_ready_ip, every bundle field holds stable.
- Reset value of every output: 0 (alu_operator_op = ALU_NOP, lsu_operator_op = LW). Busy bits and all registers reset to 0.

## Timing
- Latency: 1 cycle from accept to issue_valid_op.
- Throughput: 1 instruction/cycle when there is no hazard and issue_ready_ip = 1.
- Write-back at edge N: busy bit clear and register updated from N. A stalled consumer is accepted in the cycle after N (2-cycle load-use penalty minimum).
- Set and clear of the same busy bit in one cycle cannot occur, because WAW stalls.
- illegal_instr_op is registered: it pulses in the cycle after the illegal instruction is accepted.
- Reset asserted mid-operation: on that edge, valid, busy bits, registers and pulses clear. Write-backs and instructions presented in the reset cycle are discarded. instr_ready_op = 0 during reset.

## Test plan
- Reset, then ADDI x1,x0,5 with issue_ready_ip = 1 -> next cycle issue_valid_op = 1, ADD, a = 0, b = 5, rd_op = 1. Write-back 5 to x1 clears busy[1].
- LW x2,4(x1) (x1 = 0x100) then ADD x3,x2,x1 -> load issues with a = 0x100, b = 4, en_lsu_op = 1, LW. ADD holds instr_ready_op = 0 until wb_mem x2 = 0xDEAD, then issues with a = 0xDEAD, b = 0x100.
- SB x5,-1(x6) (x6 = 0x200, x5 = 0xAB) -> b = 0xFFFFFFFF, mem_wdata_op = 0xAB, SB, rd_op = 0, no busy bit set.
- issue_ready_ip = 0 for 3 cycles with SUB then XOR queued -> SUB bundle stable 3 cycles, instr_ready_op = 0. XOR issues the cycle after ready rises.
- Opcode 0x7F and, with NUM_REGS = 16, ADDI x20,x0,1 -> each accepted, illegal_instr_op pulses 1 cycle, issue_valid_op stays 0.
- Reset asserted while a load is outstanding -> busy cleared, issue_valid_op = 0. A later wb_mem to x2 writes without error.

Source files
------------

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage: decodes ALU, LUI, load and store instructions,
// reads operands from a local register file and issues through a busy-bit scoreboard.
package core_pkg;

   typedef enum logic [3:0] {
      ALU_NOP  = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_SLTU = 4'd10
   } alu_opcode_e;

   typedef enum logic [2:0] {
      LW  = 3'd0,
      LH  = 3'd1,
      LB  = 3'd2,
      LHU = 3'd3,
      LBU = 3'd4,
      SW  = 3'd5,
      SH  = 3'd6,
      SB  = 3'd7
   } load_store_func_code;

   localparam logic [6:0] OPCODE_OP    = 7'h33;
   localparam logic [6:0] OPCODE_OPIMM = 7'h13;
   localparam logic [6:0] OPCODE_LUI   = 7'h37;
   localparam logic [6:0] OPCODE_LOAD  = 7'h03;
   localparam logic [6:0] OPCODE_STORE = 7'h23;

endpackage

module decode_issue_stage
   import core_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                instr_valid_ip,
   input  logic [31:0]         instr_data_ip,
   output logic                instr_ready_op,
   output logic                issue_valid_op,
   input  logic                issue_ready_ip,
   output alu_opcode_e         alu_operator_op,
   output logic [XLEN-1:0]     alu_operand_a_ex_op,
   output logic [XLEN-1:0]     alu_operand_b_ex_op,
   output logic                en_lsu_op,
   output load_store_func_code lsu_operator_op,
   output logic [XLEN-1:0]     mem_wdata_op,
   output logic [4:0]          rd_op,
   output logic                illegal_instr_op,
   input  logic                wb_alu_valid_ip,
   input  logic [4:0]          wb_alu_addr_ip,
   input  logic [XLEN-1:0]     wb_alu_data_ip,
   input  logic                wb_mem_valid_ip,
   input  logic [4:0]          wb_mem_addr_ip,
   input  logic [XLEN-1:0]     wb_mem_data_ip
);

   function automatic logic in_range(input logic [4:0] a);
      return int'({27'd0, a}) < NUM_REGS;
   endfunction

   function automatic logic wr_ok(input logic [4:0] a);
      return (a != 5'd0) && in_range(a);
   endfunction

   logic [6:0] opc;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [4:0] rd;

   assign opc    = instr_data_ip[6:0];
   assign rd     = instr_data_ip[11:7];
   assign funct3 = instr_data_ip[14:12];
   assign rs1    = instr_data_ip[19:15];
   assign rs2    = instr_data_ip[24:20];
   assign funct7 = instr_data_ip[31:25];

   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt;

   assign imm_i = XLEN'($signed(instr_data_ip[31:20]));
   assign imm_s = XLEN'($signed({funct7, rd}));
   assign imm_u = XLEN'($signed({instr_data_ip[31:12], 12'd0}));
   assign shamt = XLEN'(rs2);

   // Entries at or above NUM_REGS exist but are never written or read.
   logic [XLEN-1:0] regs [32];
   logic [31:0]     busy;
   logic [31:0]     busy_nxt;

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   assign rs1_val = wr_ok(rs1) ? regs[rs1] : '0;
   assign rs2_val = wr_ok(rs2) ? regs[rs2] : '0;

   logic                dec_ok;
   logic                use_rs1;
   logic                use_rs2;
   logic                has_rd;
   logic                dec_en_lsu;
   alu_opcode_e         dec_op;
   load_store_func_code dec_lsu;
   logic [XLEN-1:0]     dec_a;
   logic [XLEN-1:0]     dec_b;
   logic [XLEN-1:0]     dec_wdata;

   always_comb begin
      dec_ok     = 1'b1;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      has_rd     = 1'b0;
      dec_en_lsu = 1'b0;
      dec_op     = ALU_ADD;
      dec_lsu    = LW;
      dec_a      = rs1_val;
      dec_b      = imm_i;
      dec_wdata  = '0;
      unique case (opc)
         OPCODE_OP: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            has_rd  = 1'b1;
            dec_b   = rs2_val;
            unique case ({funct7, funct3})
               {7'h00, 3'b000}: dec_op = ALU_ADD;
               {7'h20, 3'b000}: dec_op = ALU_SUB;
               {7'h00, 3'b001}: dec_op = ALU_SLL;
               {7'h00, 3'b010}: dec_op = ALU_SLT;
               {7'h00, 3'b011}: dec_op = ALU_SLTU;
               {7'h00, 3'b100}: dec_op = ALU_XOR;
               {7'h00, 3'b101}: dec_op = ALU_SRL;
               {7'h20, 3'b101}: dec_op = ALU_SRA;
               {7'h00, 3'b110}: dec_op = ALU_OR;
               {7'h00, 3'b111}: dec_op = ALU_AND;
               default:         dec_ok = 1'b0;
            endcase
         end
         OPCODE_OPIMM: begin
            use_rs1 = 1'b1;
            has_rd  = 1'b1;
            unique case (funct3)
               3'b000: dec_op = ALU_ADD;
               3'b010: dec_op = ALU_SLT;
               3'b011: dec_op = ALU_SLTU;
               3'b100: dec_op = ALU_XOR;
               3'b110: dec_op = ALU_OR;
               3'b111: dec_op = ALU_AND;
               3'b001: begin
                  dec_b  = shamt;
                  dec_op = ALU_SLL;
                  dec_ok = (funct7 == 7'h00);
               end
               default: begin
                  dec_b  = shamt;
                  dec_op = funct7[5] ? ALU_SRA : ALU_SRL;
                  dec_ok = (funct7 == 7'h00)
                        || (funct7 == 7'h20);
               end
            endcase
         end
         OPCODE_LUI: begin
            has_rd = 1'b1;
            dec_a  = '0;
            dec_b  = imm_u;
         end
         OPCODE_LOAD: begin
            use_rs1    = 1'b1;
            has_rd     = 1'b1;
            dec_en_lsu = 1'b1;
            unique case (funct3)
               3'b000:  dec_lsu = LB;
               3'b001:  dec_lsu = LH;
               3'b010:  dec_lsu = LW;
               3'b100:  dec_lsu = LBU;
               3'b101:  dec_lsu = LHU;
               default: dec_ok  = 1'b0;
            endcase
         end
         OPCODE_STORE: begin
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
            dec_en_lsu = 1'b1;
            dec_b      = imm_s;
            dec_wdata  = rs2_val;
            unique case (funct3)
               3'b000:  dec_lsu = SB;
               3'b001:  dec_lsu = SH;
               3'b010:  dec_lsu = SW;
               default: dec_ok  = 1'b0;
            endcase
         end
         default: dec_ok = 1'b0;
      endcase
   end

   logic       legal;
   logic [4:0] rd_eff;
   logic       hazard;
   logic       accept;
   logic       issue_load;

   assign legal = dec_ok
               && (!use_rs1 || in_range(rs1))
               && (!use_rs2 || in_range(rs2))
               && (!has_rd || in_range(rd));

   assign rd_eff = has_rd ? rd : 5'd0;

   assign hazard = (use_rs1 && busy[rs1])
                || (use_rs2 && busy[rs2])
                || ((rd_eff != 5'd0) && busy[rd_eff]);

   // Illegal words bypass stalls so a bad fetch never wedges decode.
   assign instr_ready_op = !reset
      && (!legal
          || ((!issue_valid_op || issue_ready_ip)
              && !hazard));

   assign accept     = instr_valid_ip && instr_ready_op;
   assign issue_load = accept && legal;

   always_comb begin
      busy_nxt = busy;
      if (wb_alu_valid_ip) busy_nxt[wb_alu_addr_ip] = 1'b0;
      if (wb_mem_valid_ip) busy_nxt[wb_mem_addr_ip] = 1'b0;
      if (issue_load && (rd_eff != 5'd0)) busy_nxt[rd_eff] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // Memory port is written last so it wins an address collision.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         if (wb_alu_valid_ip && wr_ok(wb_alu_addr_ip))
            regs[wb_alu_addr_ip] <= wb_alu_data_ip;
         if (wb_mem_valid_ip && wr_ok(wb_mem_addr_ip))
            regs[wb_mem_addr_ip] <= wb_mem_data_ip;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         issue_valid_op      <= 1'b0;
         alu_operator_op     <= ALU_NOP;
         alu_operand_a_ex_op <= '0;
         alu_operand_b_ex_op <= '0;
         en_lsu_op           <= 1'b0;
         lsu_operator_op     <= LW;
         mem_wdata_op        <= '0;
         rd_op               <= 5'd0;
         illegal_instr_op    <= 1'b0;
      end else begin
         illegal_instr_op <= accept && !legal;
         if (issue_load) begin
            issue_valid_op      <= 1'b1;
            alu_operator_op     <= dec_op;
            alu_operand_a_ex_op <= dec_a;
            alu_operand_b_ex_op <= dec_b;
            en_lsu_op           <= dec_en_lsu;
            lsu_operator_op     <= dec_lsu;
            mem_wdata_op        <= dec_wdata;
            rd_op               <= rd_eff;
         end else if (issue_ready_ip) begin
            issue_valid_op <= 1'b0;
         end
      end
   end

endmodule
